// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   DEFAULT_WIDTH : default operand/result width
//   ST_*          : FSM state encodings
//   state_e       : typed FSM state built on those encodings
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor slice: computes x - y - br.
//   x, y, br : minuend bit, subtrahend bit, borrow-in
//   d        : difference bit
//   br_next  : borrow-out
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic br_next
);

  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~x & br) | (y & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin over WIDTH clocks, LSB first.
//   clk, rst_n          : clock, async active-low reset
//   start, a, b, bin    : operand valid + operands, taken when in_ready=1
//   in_ready, busy      : idle / shifting indicators (decoded from state)
//   diff, bout          : result and final borrow, valid while out_valid=1
//   out_valid, out_ready: result handshake; result held until acknowledged
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;

  logic               cell_d;
  logic               cell_br_next;

  full_sub_cell u_cell (
    .x       (a_sr_q[0]),
    .y       (b_sr_q[0]),
    .br      (borrow_q),
    .d       (cell_d),
    .br_next (cell_br_next)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          count_d  = '0;
          diff_d   = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        // Result fills from the top so that after WIDTH shifts bit 0 is the LSB.
        diff_d   = {cell_d, diff_q[WIDTH-1:1]};
        borrow_d = cell_br_next;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LastBit) begin
          bout_d  = cell_br_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases with literal
// expectations plus an exhaustive sweep with random consumer delay, all shadowed by a
// cycle-level behavioural model that is compared against the DUT on every negedge.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         in_ready, busy, out_valid, bout;
  logic [W-1:0] diff;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_ready  (in_ready),
    .busy      (busy),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing (m_left edges to go), 2 holding result.
  int           m_phase = 0;
  int           m_left = 0;
  logic [W:0]   m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_res   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
          m_left  = W;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
      chk("model_busy", {31'b0, busy}, {31'b0, m_phase == 1});
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
      if (m_phase == 2) chk("model_result", {27'b0, bout, diff}, {27'b0, m_res});
    end
  end

  // Advance to just after the next negedge (inputs change here, away from posedge).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  // Issue one op, wait for out_valid; returns result and edges from accept to out_valid.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output logic [W:0] res, output int lat);
    wait_idle();
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    res = {bout, diff};
  endtask

  task automatic handshake(input int delay);
    for (int i = 0; i < delay; i++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_diff"}, {28'b0, diff}, 32'd0);
    chk({name, "_bout"}, {31'b0, bout}, 32'd0);
  endtask

  logic [W:0] res;
  int         lat;

  initial begin
    #3;
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    step();

    // 9 - 3
    issue(4'd9, 4'd3, 1'b0, res, lat);
    chk("lat_9_3", lat, W);
    chk("res_9_3", {27'b0, res}, {27'b0, 1'b0, 4'd6});
    handshake(0);
    chk("ready_after_9_3", {31'b0, in_ready}, 32'd1);

    issue(4'd3, 4'd9, 1'b0, res, lat);
    chk("res_3_9", {27'b0, res}, {27'b0, 1'b1, 4'hA});
    handshake(0);
    issue(4'd0, 4'd0, 1'b1, res, lat);
    chk("res_0_0_1", {27'b0, res}, {27'b0, 1'b1, 4'hF});
    handshake(1);
    issue(4'd15, 4'd15, 1'b0, res, lat);
    chk("res_15_15", {27'b0, res}, 32'd0);
    handshake(2);

    // Backpressure: result must sit still for 10 cycles.
    issue(4'd12, 4'd5, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_diff", {28'b0, diff}, 32'd7);
      step();
    end
    handshake(0);
    chk("bp_ready_after", {31'b0, in_ready}, 32'd1);

    // start held high through SHIFT with new operands: must not disturb the result.
    wait_idle();
    a = 4'd8;
    b = 4'd2;
    bin = 1'b0;
    start = 1'b1;
    step();
    a = 4'd1;
    b = 4'd1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("hold_lat", lat, W);
    chk("hold_res", {27'b0, bout, diff}, {27'b0, 1'b0, 4'd6});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_no_accept_on_ack", {31'b0, in_ready}, 32'd1);
    step();
    chk("hold_accept_next", {31'b0, busy}, 32'd1);
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("hold_second_res", {27'b0, bout, diff}, 32'd0);
    handshake(0);

    // Asynchronous reset mid-SHIFT (two bits processed).
    wait_idle();
    a = 4'd13;
    b = 4'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    step();
    rst_n = 1'b1;
    issue(4'd5, 4'd2, 1'b0, res, lat);
    chk("after_abort_res", {27'b0, res}, {27'b0, 1'b0, 4'd3});
    handshake(0);

    // Exhaustive sweep with random consumer delay.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [W:0] exp;
          exp = 5'(ia - ib - ic);
          issue(4'(ia), 4'(ib), 1'(ic), res, lat);
          chk("sweep", {27'b0, res}, {27'b0, exp});
          handshake(int'($urandom_range(0, 3)));
        end
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
